// File: rtl/nco_pkg.sv
// nco_pkg -- shared constants and wavetable generation for nco_multichannel.
//   Default parameter values for the NCO slice.
//   sineSample(): one unsigned sine-table entry, evaluated per ROM index at
//   elaboration.
package nco_pkg;

  localparam int NCH_DEFAULT      = 4;
  localparam int PHASE_W_DEFAULT  = 16;
  localparam int ADDR_W_DEFAULT   = 7;
  localparam int SAMPLE_W_DEFAULT = 8;
  localparam int OUT_W_DEFAULT    = 12;

  localparam real PI = 3.14159265358979323846;

  // The table is centred on mid-scale with an amplitude one LSB short of
  // half-scale. This keeps it symmetric about mid-scale
  // (ROM[i] + ROM[N-i] = 2*mid), and the peaks land on 2^SAMPLE_W-1 and 1.
  // Halves round up.
  function automatic int sineSample(int index, int addrW, int sampleW);
    real mid;
    real amp;
    real x;
    mid = 2.0 ** (sampleW - 1);
    amp = mid - 1.0;
    x   = mid + amp * $sin(2.0 * PI * real'(index) / (2.0 ** addrW));
    return $rtoi($floor(x + 0.5));
  endfunction

endpackage

// File: rtl/nco_wavetable.sv
// nco_wavetable -- sine ROM with two registered read ports.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Addr       : table index for the current sample
//   Samp1      : ROM[Addr], registered
//   Samp2      : ROM[Addr+1], registered. The index wraps so that the last
//                entry interpolates toward entry 0.
module nco_wavetable
  import nco_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [ADDR_W-1:0]   Addr,
  output logic [SAMPLE_W-1:0] Samp1,
  output logic [SAMPLE_W-1:0] Samp2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [SAMPLE_W-1:0] romTable [DEPTH];
  logic [ADDR_W-1:0]   addrNext;

  for (genvar i = 0; i < DEPTH; i++) begin : gRom
    assign romTable[i] = SAMPLE_W'(sineSample(i, ADDR_W, SAMPLE_W));
  end

  // Natural ADDR_W-bit overflow provides the wrap to entry 0.
  assign addrNext = Addr + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Samp1 <= '0;
      Samp2 <= '0;
    end else begin
      Samp1 <= romTable[Addr];
      Samp2 <= romTable[addrNext];
    end
  end

endmodule

// File: rtl/nco_multichannel.sv
// nco_multichannel -- time-multiplexed multichannel NCO with linear
// interpolation between adjacent sine-table entries.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   En         : advance the channel slot and issue one sample
//   Clear      : synchronous clear of accumulators, slot counter and pipeline
//   Load       : config write strobe. LdSel selects the target register
//                (0 = increment, 1 = offset), LdChan the channel, and
//                LdData the value.
//   Output     : interpolated sample, unsigned offset-binary
//   OutChan    : channel that produced Output
//   Valid      : Output/OutChan are valid this cycle
// Pipeline: phase register -> registered ROM reads -> interpolation register.
module nco_multichannel
  import nco_pkg::*;
#(
  parameter int NCH      = NCH_DEFAULT,
  parameter int PHASE_W  = PHASE_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int OUT_W    = OUT_W_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     En,
  input  logic                     Clear,
  input  logic                     Load,
  input  logic                     LdSel,
  input  logic [$clog2(NCH)-1:0]   LdChan,
  input  logic [PHASE_W-1:0]       LdData,
  output logic [OUT_W-1:0]         Output,
  output logic [$clog2(NCH)-1:0]   OutChan,
  output logic                     Valid
);

  localparam int CH_W   = $clog2(NCH);
  localparam int FRAC_W = PHASE_W - ADDR_W;
  localparam int INT_W  = SAMPLE_W + FRAC_W + 1;

  // Per-channel state
  logic [PHASE_W-1:0] acc [NCH];
  logic [PHASE_W-1:0] inc [NCH];
  logic [PHASE_W-1:0] off [NCH];
  logic [CH_W-1:0]    slot;

  // Stage 0: phase
  logic [PHASE_W-1:0] phase0;
  logic [CH_W-1:0]    chan0;
  logic               valid0;

  // Stage 1: ROM samples, with fraction and channel carried alongside
  logic [SAMPLE_W-1:0] samp1;
  logic [SAMPLE_W-1:0] samp2;
  logic [FRAC_W-1:0]   frac1;
  logic [CH_W-1:0]     chan1;
  logic                valid1;

  // Interpolation arithmetic
  logic signed [SAMPLE_W:0]  diffS;
  logic signed [INT_W-1:0]   diffX;
  logic signed [INT_W-1:0]   fracX;
  logic signed [INT_W-1:0]   baseX;
  logic signed [INT_W-1:0]   interp;

  // Configuration registers. A Load is taken whatever En and Clear are doing.
  // A slot issued at the same edge still reads the old value, because it
  // samples the register before this edge updates it.
  // NOTE: these per-channel arrays are plain flops rather than a RAM macro,
  // so giving them an asynchronous reset is legitimate and cheap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        inc[i] <= '0;
        off[i] <= '0;
      end
    end else if (Load) begin
      if (LdSel) off[LdChan] <= LdData;
      else       inc[LdChan] <= LdData;
    end
  end

  // Slot counter, accumulators and stage 0. Clear takes priority over En.
  // NOTE: state is updated with non-blocking assignments only, so the phase
  // computed here uses acc[slot] as it was before this edge's update.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      slot   <= '0;
      phase0 <= '0;
      chan0  <= '0;
      valid0 <= 1'b0;
    end else if (Clear) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      slot   <= '0;
      valid0 <= 1'b0;
    end else if (En) begin
      phase0    <= acc[slot] + off[slot];
      chan0     <= slot;
      valid0    <= 1'b1;
      acc[slot] <= acc[slot] + inc[slot];
      slot      <= slot + 1'b1;   // NCH is a power of two: wraps naturally
    end else begin
      valid0 <= 1'b0;
    end
  end

  nco_wavetable #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) uWavetable (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Addr  (phase0[PHASE_W-1 -: ADDR_W]),
    .Samp1 (samp1),
    .Samp2 (samp2)
  );

  // Stage 1 side-band, kept aligned with the registered ROM reads
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frac1  <= '0;
      chan1  <= '0;
      valid1 <= 1'b0;
    end else begin
      frac1  <= phase0[FRAC_W-1:0];
      chan1  <= chan0;
      valid1 <= valid0 && !Clear;
    end
  end

  // interp = s1*2^FRAC_W + (s2-s1)*frac. The slope is signed, but the sum
  // always lies between s1 and s2 scaled, so it is never negative.
  // NOTE: every signal is given a value before any other statement, so no
  // latch can be inferred.
  always_comb begin
    diffS  = $signed({1'b0, samp2}) - $signed({1'b0, samp1});
    diffX  = INT_W'(diffS);
    fracX  = $signed(INT_W'(frac1));
    baseX  = $signed({1'b0, samp1, {FRAC_W{1'b0}}});
    interp = baseX + diffX * fracX;
  end

  // Stage 2: output register. Output and OutChan hold between valid samples.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Output  <= '0;
      OutChan <= '0;
      Valid   <= 1'b0;
    end else begin
      Valid <= valid1 && !Clear;
      if (valid1 && !Clear) begin
        Output  <= interp[SAMPLE_W+FRAC_W-1 -: OUT_W];
        OutChan <= chan1;
      end
    end
  end

endmodule

// File: tb/tb_nco_multichannel.sv
// tb_nco_multichannel -- directed, scoreboard-checked bench for
// nco_multichannel.
// A behavioural model updates at each rising edge. It pushes the expected
// {channel, value, issue cycle} for every issued slot. Each Valid output is
// popped and compared 1 ns after the edge.
module tb_nco_multichannel;

  localparam int NCH      = 4;
  localparam int PHASE_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int SAMPLE_W = 8;
  localparam int OUT_W    = 12;
  localparam int CH_W     = 2;

  logic               Clk;
  logic               Rst_n;
  logic               En;
  logic               Clear;
  logic               Load;
  logic               LdSel;
  logic [CH_W-1:0]    LdChan;
  logic [PHASE_W-1:0] LdData;
  logic [OUT_W-1:0]   Output;
  logic [CH_W-1:0]    OutChan;
  logic               Valid;

  nco_multichannel #(
    .NCH      (NCH),
    .PHASE_W  (PHASE_W),
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .En      (En),
    .Clear   (Clear),
    .Load    (Load),
    .LdSel   (LdSel),
    .LdChan  (LdChan),
    .LdData  (LdData),
    .Output  (Output),
    .OutChan (OutChan),
    .Valid   (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int chan;
    int value;   // -1: table entry not known to the bench, value unchecked
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  logic [PHASE_W-1:0] mAcc [NCH];
  logic [PHASE_W-1:0] mInc [NCH];
  logic [PHASE_W-1:0] mOff [NCH];
  int                 mSlot;
  logic [PHASE_W-1:0] mPhase;
  exp_t               newE;
  logic               hasNew;
  exp_t               popE;

  task automatic check(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference sine entries used by the directed scenarios
  function automatic int romKnown(int a);
    case (a)
      0:       return 128;
      1:       return 134;
      32:      return 255;
      64:      return 128;
      96:      return 1;
      127:     return 122;
      default: return -1;
    endcase
  endfunction

  function automatic int expectOut(logic [PHASE_W-1:0] ph);
    int a, f, s1, s2, v;
    a  = int'(ph[15:9]);
    f  = int'(ph[8:0]);
    s1 = romKnown(a);
    s2 = romKnown((a + 1) % 128);
    if (s1 < 0) return -1;
    if (f == 0) return s1 * 16;
    if (s2 < 0) return -1;
    v = s1 * 512 + (s2 - s1) * f;
    return v / 32;
  endfunction

  // Model and scoreboard
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sb.delete();
      mSlot = 0;
      cyc   = 0;
      for (int i = 0; i < NCH; i++) begin
        mAcc[i] = '0;
        mInc[i] = '0;
        mOff[i] = '0;
      end
    end else begin
      cyc++;
      hasNew = 1'b0;
      if (Clear) begin
        sb.delete();
        for (int i = 0; i < NCH; i++) mAcc[i] = '0;
        mSlot = 0;
      end else if (En) begin
        mPhase = mAcc[mSlot] + mOff[mSlot];
        newE   = '{chan: mSlot, value: expectOut(mPhase), cyc: cyc};
        hasNew = 1'b1;
        mAcc[mSlot] = mAcc[mSlot] + mInc[mSlot];
        mSlot = (mSlot + 1) % NCH;
      end
      if (Load) begin
        if (LdSel) mOff[LdChan] = LdData;
        else       mInc[LdChan] = LdData;
      end
      #1;
      if (Valid) begin
        check("sb_nonempty_on_valid", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          popE = sb.pop_front();
          check("out_chan", int'(OutChan), popE.chan);
          check("latency", cyc - popE.cyc, 2);
          if (popE.value >= 0) check("output", int'(Output), popE.value);
        end
      end
      if (hasNew) sb.push_back(newE);
    end
  end

  task automatic load(input logic sel, input int ch, input int data);
    Load   = 1'b1;
    LdSel  = sel;
    LdChan = CH_W'(ch);
    LdData = PHASE_W'(data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int firstK;
    int lowCount;

    Rst_n = 1'b0; En = 1'b0; Clear = 1'b0; Load = 1'b0;
    LdSel = 1'b0; LdChan = '0; LdData = '0;
    #12;
    check("reset_output",  int'(Output), 0);
    check("reset_outchan", int'(OutChan), 0);
    check("reset_valid",   int'(Valid), 0);
    @(negedge Clk); Rst_n = 1'b1;

    // inc[0]=0x0200: ch0 outputs 2048, 2144, ...; latency from the first En edge
    @(negedge Clk); load(1'b0, 0, 16'h0200);
    @(negedge Clk); Load = 1'b0; En = 1'b1;
    firstK = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #2;
      if (Valid) begin firstK = k; break; end
    end
    check("first_valid_edges", firstK, 3);
    repeat (12) @(negedge Clk);

    // Clear together with Load, then offsets and the ch2 increment
    En = 1'b0; Clear = 1'b1; load(1'b0, 0, 0);
    @(negedge Clk); Clear = 1'b0; load(1'b1, 0, 16'h0100);
    @(negedge Clk); load(1'b1, 1, 16'hFF00);
    @(negedge Clk); load(1'b0, 2, 16'h4000);
    @(negedge Clk); Load = 1'b0; En = 1'b1;
    repeat (32) @(negedge Clk);

    // En low: in-flight samples drain, nothing new is issued
    En = 1'b0;
    repeat (5) @(negedge Clk);
    check("drain_empty", sb.size(), 0);

    // Load inc[0] at the edge of a ch0 slot: that slot keeps the old increment
    Clear = 1'b1; load(1'b1, 0, 0);
    @(negedge Clk); Clear = 1'b0; En = 1'b1; load(1'b0, 0, 16'h4000);
    @(negedge Clk); Load = 1'b0;
    repeat (24) @(negedge Clk);

    // Clear mid-stream while En stays high
    Clear = 1'b1; load(1'b1, 0, 16'h0100);
    lowCount = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #2;
      if (k == 1) begin Clear = 1'b0; Load = 1'b0; end
      if (Valid) break;
      lowCount++;
    end
    check("clear_valid_low_cycles", lowCount, 3);
    repeat (12) @(negedge Clk);

    // Asynchronous reset mid-cycle
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    check("async_rst_output",  int'(Output), 0);
    check("async_rst_outchan", int'(OutChan), 0);
    check("async_rst_valid",   int'(Valid), 0);
    @(negedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    firstK = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #2;
      if (Valid) begin firstK = k; break; end
    end
    check("first_valid_after_reset", firstK, 3);
    repeat (12) @(negedge Clk);

    En = 1'b0;
    repeat (5) @(negedge Clk);
    check("final_drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
